// File: rtl/div_unit.sv
// ----------------------------------------------------------------------------
// div_unit
//
// Multi-cycle integer divider for the RISC-V M-extension divide/remainder
// instructions. It uses radix-2 restoring division and produces one quotient
// bit per BUSY cycle. Division by zero and signed overflow bypass the
// iterative datapath and complete on the cycle after accept.
//
// Ports:
//   clk        - sole clock, rising edge
//   reset_n    - asynchronous active-low reset
//   flush      - synchronous abort of any in-flight operation or held result
//   in_valid   - request present
//   in_ready   - unit idle and able to accept a request
//   op         - 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   rs1        - dividend
//   rs2        - divisor
//   out_valid  - result present (held until consumed)
//   out_ready  - consumer accepts the result
//   result     - quotient or remainder, depending on op
// ----------------------------------------------------------------------------
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs1,
    input  logic [WIDTH-1:0] rs2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    state_t           next_state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] rem;
    logic             neg_quot;
    logic             neg_rem;
    logic             rem_sel;

    logic             is_signed;
    logic             is_rem;
    logic             div_zero;
    logic             overflow;
    logic             special;
    logic [WIDTH-1:0] special_result;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic             accept;
    logic             last_step;
    logic [WIDTH:0]   rem_shift;
    logic             ge;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quot_next;
    logic [WIDTH-1:0] final_value;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Decode the incoming request: operand magnitudes for the unsigned core,
    // and the two cases that bypass iteration. The dividend magnitude of the
    // most-negative value wraps to itself, which is the correct unsigned
    // magnitude.
    always_comb begin
        is_signed = ~op[0];
        is_rem    = op[1];
        div_zero  = (rs2 == '0);
        overflow  = is_signed && (rs1 == MIN_NEG) && (rs2 == '1);
        special   = div_zero || overflow;
        if (div_zero) begin
            special_result = is_rem ? rs1 : '1;
        end else begin
            special_result = is_rem ? '0 : rs1;
        end
        abs_a  = (is_signed && rs1[WIDTH-1]) ? -rs1 : rs1;
        abs_b  = (is_signed && rs2[WIDTH-1]) ? -rs2 : rs2;
        accept = (state == IDLE) && in_valid && !flush;
    end

    // One restoring-division step. The partial remainder always stays below
    // the divisor, so after a successful subtract the difference fits in
    // WIDTH bits and the wrapped subtraction is exact.
    always_comb begin
        rem_shift = {rem, quot[WIDTH-1]};
        ge        = (rem_shift >= {1'b0, divisor});
        diff      = rem_shift[WIDTH-1:0] - divisor;
        rem_next  = ge ? diff : rem_shift[WIDTH-1:0];
        quot_next = {quot[WIDTH-2:0], ge};
        last_step = (count == CW'(1));
        if (rem_sel) begin
            final_value = neg_rem ? -rem_next : rem_next;
        end else begin
            final_value = neg_quot ? -quot_next : quot_next;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. Flush overrides both accept and the result handshake.
    always_comb begin
        next_state = state;
        if (flush) begin
            next_state = IDLE;
        end else begin
            unique case (state)
                IDLE: if (accept) next_state = special ? DONE : BUSY;
                BUSY: if (last_step) next_state = DONE;
                DONE: if (out_ready) next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    // Datapath: latch operands on accept, iterate while BUSY, and write the
    // sign-corrected result on the final step so that result is a plain
    // register while DONE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count    <= '0;
            divisor  <= '0;
            quot     <= '0;
            rem      <= '0;
            neg_quot <= 1'b0;
            neg_rem  <= 1'b0;
            rem_sel  <= 1'b0;
            result   <= '0;
        end else if (accept) begin
            rem      <= '0;
            quot     <= abs_a;
            divisor  <= abs_b;
            neg_quot <= is_signed && (rs1[WIDTH-1] ^ rs2[WIDTH-1]);
            neg_rem  <= is_signed && rs1[WIDTH-1];
            rem_sel  <= is_rem;
            count    <= special ? '0 : CW'(WIDTH);
            if (special) begin
                result <= special_result;
            end
        end else if (state == BUSY && !flush) begin
            rem   <= rem_next;
            quot  <= quot_next;
            count <= count - CW'(1);
            if (last_step) begin
                result <= final_value;
            end
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// ----------------------------------------------------------------------------
// tb_div_unit
//
// Directed self-checking bench for div_unit at WIDTH=32. Expected values are
// hand-computed RISC-V M-extension results.
// ----------------------------------------------------------------------------
module tb_div_unit;

    localparam int W = 32;

    logic         clk;
    logic         reset_n;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   op;
    logic [W-1:0] rs1;
    logic [W-1:0] rs2;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;

    int n_asserts;
    int n_fail;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    div_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .rs1       (rs1),
        .rs2       (rs2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts the check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        n_asserts++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Present one request for a single edge; the unit must be ready for it.
    task automatic applyStimulus(input string tag, input logic [1:0] o,
                                 input logic [W-1:0] a, input logic [W-1:0] b);
        op       = o;
        rs1      = a;
        rs2      = b;
        in_valid = 1'b1;
        checkOutput({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Count edges after accept until out_valid rises, bounded.
    task automatic waitResult(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    // Full operation with out_ready high: latency, value, and return to IDLE.
    task automatic runOp(input string tag, input logic [1:0] o,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp, input int exp_lat);
        int lat;
        applyStimulus(tag, o, a, b);
        waitResult(lat);
        checkOutput({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        checkOutput({tag, "_result"}, 64'(result), 64'(exp));
        @(posedge clk);
        #1;
        checkOutput({tag, "_idle_after"}, 64'({out_valid, in_ready}), 64'b01);
    endtask

    initial begin
        int lat;
        logic seen;
        n_asserts = 0;
        n_fail    = 0;
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op        = 2'b00;
        rs1       = '0;
        rs2       = '0;

        // Reset state.
        #12;
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_result", 64'(result), 64'd0);
        reset_n = 1'b1;

        // Accepted on the first edge after reset release.
        runOp("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 32);
        runOp("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, 32);

        // Signed cases.
        runOp("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32);
        runOp("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32);
        runOp("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32);
        runOp("rem_7_m2", OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 32);
        runOp("div_m8_m3", OP_DIV, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'd2, 32);
        runOp("rem_m8_m3", OP_REM, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32);
        runOp("div_minneg_1", OP_DIV, 32'h8000_0000, 32'd1, 32'h8000_0000, 32);

        // Unsigned treatment of the same bit patterns.
        runOp("divu_fff9_2", OP_DIVU, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32);
        runOp("remu_fff9_2", OP_REMU, 32'hFFFF_FFF9, 32'd2, 32'd1, 32);
        runOp("divu_max_1", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32);
        runOp("divu_same", OP_DIVU, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'd1, 32);

        // Special cases complete one edge after accept.
        runOp("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
        runOp("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0);
        runOp("divu_zero", OP_DIVU, 32'd1234, 32'd0, 32'hFFFF_FFFF, 0);
        runOp("remu_5_zero", OP_REMU, 32'd5, 32'd0, 32'd5, 0);
        runOp("div_5_zero", OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
        runOp("rem_m7_zero", OP_REM, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 0);

        // Backpressure: result held for 10 cycles; inputs ignored while DONE.
        out_ready = 1'b0;
        applyStimulus("hold", OP_DIVU, 32'd1000, 32'd10);
        waitResult(lat);
        checkOutput("hold_latency", 64'(lat), 64'd32);
        in_valid = 1'b1;
        op       = OP_REMU;
        rs1      = 32'd77;
        rs2      = 32'd0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checkOutput("hold_state", 64'({out_valid, in_ready}), 64'b10);
            checkOutput("hold_result", 64'(result), 64'd100);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("hold_release", 64'({out_valid, in_ready}), 64'b01);

        // Flush in the tenth BUSY cycle discards the operation.
        applyStimulus("flush_busy", OP_DIVU, 32'd1000, 32'd7);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        checkOutput("flush_busy_pre", 64'({out_valid, in_ready}), 64'b00);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checkOutput("flush_busy_post", 64'({out_valid, in_ready}), 64'b01);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        checkOutput("flush_busy_no_result", 64'(seen), 64'd0);

        // Flush wins over accept of a special-case request.
        in_valid = 1'b1;
        op       = OP_DIVU;
        rs1      = 32'd3;
        rs2      = 32'd0;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        checkOutput("flush_accept", 64'({out_valid, in_ready}), 64'b01);

        // Flush while DONE drops the held result.
        out_ready = 1'b0;
        applyStimulus("flush_done", OP_REMU, 32'd9, 32'd0);
        checkOutput("flush_done_pre", 64'(out_valid), 64'd1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush     = 1'b0;
        out_ready = 1'b1;
        checkOutput("flush_done_post", 64'({out_valid, in_ready}), 64'b01);

        // Asynchronous reset mid-BUSY.
        applyStimulus("rst_busy", OP_DIVU, 32'd500, 32'd3);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("rst_busy_async", 64'({out_valid, in_ready}), 64'b01);
        checkOutput("rst_busy_result", 64'(result), 64'd0);
        reset_n = 1'b1;
        runOp("divu_9_3", OP_DIVU, 32'd9, 32'd3, 32'd3, 32);

        // Asynchronous reset mid-DONE never lets the result out.
        out_ready = 1'b0;
        applyStimulus("rst_done", OP_DIVU, 32'd50, 32'd5);
        waitResult(lat);
        checkOutput("rst_done_result", 64'(result), 64'd10);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("rst_done_async", 64'({out_valid, in_ready}), 64'b01);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst_done_after", 64'({out_valid, in_ready}), 64'b01);
        runOp("rem_m9_4", OP_REM, 32'hFFFF_FFF7, 32'd4, 32'hFFFF_FFFF, 32);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

    // Hard time limit so a stuck DUT still ends the run.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: observed no completion required completion");
        $fatal(1, "[TB] timeout");
    end

endmodule
